// File: rtl/cpu64_l2_pkg.sv
// Shared geometry, state-bit positions and sequencer encoding for the L2 storage slice.
package cpu64_l2_pkg;

   localparam int unsigned L2_WAYS           = 16;
   localparam int unsigned L2_SETS           = 256;
   localparam int unsigned L2_WORDS_PER_LINE = 8;
   localparam int unsigned L2_DATA_W         = 64;
   localparam int unsigned L2_TAG_W          = 50;

   localparam int unsigned STATE_VALID = 0;
   localparam int unsigned STATE_DIRTY = 1;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } l2_fsm_e;

endpackage

// File: rtl/cpu64_l2_hit_detect.sv
// Parallel tag compare: raw match vector, lowest-way one-hot hit and multi-hit flag.
module cpu64_l2_hit_detect #(
   parameter int unsigned WAYS  = 16,
   parameter int unsigned TAG_W = 50
) (
   input  logic [WAYS-1:0]       valid,
   input  logic [WAYS*TAG_W-1:0] tag_flat,
   input  logic [TAG_W-1:0]      cmp_tag,
   output logic                  hit,
   output logic [WAYS-1:0]       hit_way,
   output logic                  multi_hit
);

   logic [WAYS-1:0] match;

   always_comb begin
      match = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         match[w] = valid[w] && (tag_flat[w*TAG_W +: TAG_W] == cmp_tag);
      end
   end

   // x & -x isolates the lowest set bit; x & (x-1) is non-zero iff 2+ bits set
   assign hit_way   = match & (~match + WAYS'(1));
   assign hit       = |match;
   assign multi_hit = |(match & (match - WAYS'(1)));

endmodule

// File: rtl/cpu64_l2_arrays_pipe.sv
// L2 data/tag/state storage with registered 1-cycle read, post-reset invalidation sweep and hit detect.
module cpu64_l2_arrays_pipe
   import cpu64_l2_pkg::*;
#(
   parameter int unsigned WAYS           = L2_WAYS,
   parameter int unsigned SETS           = L2_SETS,
   parameter int unsigned WORDS_PER_LINE = L2_WORDS_PER_LINE,
   parameter int unsigned DATA_W         = L2_DATA_W,
   parameter int unsigned TAG_W          = L2_TAG_W,
   parameter int unsigned IDX_W          = $clog2(SETS),
   parameter int unsigned WORD_W         = $clog2(WORDS_PER_LINE),
   parameter int unsigned WAY_W          = $clog2(WAYS)
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [IDX_W-1:0]         req_index_i,
   input  logic [WORD_W-1:0]        req_word_i,
   input  logic [WAY_W-1:0]         req_way_i,
   input  logic                     req_data_we_i,
   input  logic [DATA_W/8-1:0]      req_be_i,
   input  logic [DATA_W-1:0]        req_wdata_i,
   input  logic                     req_tag_we_i,
   input  logic [TAG_W-1:0]         req_tag_i,
   input  logic [1:0]               req_state_i,
   input  logic [TAG_W-1:0]         req_cmp_tag_i,
   output logic                     rsp_valid_o,
   output logic [DATA_W-1:0]        rsp_rdata_o,
   output logic [WAYS*DATA_W-1:0]   rsp_rdata_way_flat_o,
   output logic [WAYS*TAG_W-1:0]    rsp_tag_way_flat_o,
   output logic [WAYS*2-1:0]        rsp_state_way_flat_o,
   output logic                     rsp_hit_o,
   output logic [WAYS-1:0]          rsp_hit_way_o,
   output logic                     rsp_multi_hit_o,
   output logic                     init_done_o
);

   localparam int unsigned LINE_W = IDX_W + WORD_W;
   localparam int unsigned BYTES  = DATA_W / 8;

   l2_fsm_e          state, next_state;
   logic [IDX_W-1:0] sweep_cnt, next_sweep_cnt;
   logic             accept;

   logic [DATA_W-1:0] data_mem  [WAYS][SETS*WORDS_PER_LINE];
   logic [TAG_W-1:0]  tag_mem   [WAYS][SETS];
   logic [1:0]        state_mem [WAYS][SETS];

   logic [LINE_W-1:0]      word_addr;
   logic [WAYS*DATA_W-1:0] rd_data_flat;
   logic [WAYS*TAG_W-1:0]  rd_tag_flat;
   logic [WAYS*2-1:0]      rd_state_flat;
   logic [WAYS-1:0]        rd_valid;
   logic                   hit;
   logic [WAYS-1:0]        hit_way;
   logic                   multi_hit;

   // ---------------- sequencer ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= INIT;
         sweep_cnt <= '0;
      end else begin
         state     <= next_state;
         sweep_cnt <= next_sweep_cnt;
      end
   end

   always_comb begin
      next_state     = state;
      next_sweep_cnt = sweep_cnt;
      case (state)
         INIT: begin
            next_sweep_cnt = sweep_cnt + 1'b1;
            if (sweep_cnt == IDX_W'(SETS - 1)) next_state = READY;
         end
         READY: next_state = READY;
         default: next_state = INIT;
      endcase
   end

   assign req_ready_o = (state == READY) && !rst_i;
   assign init_done_o = req_ready_o;
   assign accept      = req_valid_i && req_ready_o;

   // ---------------- storage ----------------
   assign word_addr = {req_index_i, req_word_i};

   always_ff @(posedge clk_i) begin
      if (!rst_i && state == INIT) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            tag_mem[w][sweep_cnt]   <= '0;
            state_mem[w][sweep_cnt] <= '0;
         end
      end else if (accept && req_tag_we_i) begin
         tag_mem[req_way_i][req_index_i]   <= req_tag_i;
         state_mem[req_way_i][req_index_i] <= req_state_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (accept && req_data_we_i) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (req_be_i[b]) data_mem[req_way_i][word_addr][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
         end
      end
   end

   // Pre-write contents of every way; sampled into the response registers at the accept edge
   always_comb begin
      rd_data_flat  = '0;
      rd_tag_flat   = '0;
      rd_state_flat = '0;
      rd_valid      = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         rd_data_flat[w*DATA_W +: DATA_W] = data_mem[w][word_addr];
         rd_tag_flat[w*TAG_W +: TAG_W]    = tag_mem[w][req_index_i];
         rd_state_flat[w*2 +: 2]          = state_mem[w][req_index_i];
         rd_valid[w]                      = state_mem[w][req_index_i][STATE_VALID];
      end
   end

   cpu64_l2_hit_detect #(
      .WAYS  (WAYS),
      .TAG_W (TAG_W)
   ) u_hit_detect (
      .valid     (rd_valid),
      .tag_flat  (rd_tag_flat),
      .cmp_tag   (req_cmp_tag_i),
      .hit       (hit),
      .hit_way   (hit_way),
      .multi_hit (multi_hit)
   );

   // ---------------- response registers ----------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_o          <= 1'b0;
         rsp_rdata_o          <= '0;
         rsp_rdata_way_flat_o <= '0;
         rsp_tag_way_flat_o   <= '0;
         rsp_state_way_flat_o <= '0;
         rsp_hit_o            <= 1'b0;
         rsp_hit_way_o        <= '0;
         rsp_multi_hit_o      <= 1'b0;
      end else begin
         rsp_valid_o <= accept;
         if (accept) begin
            rsp_rdata_o          <= rd_data_flat[req_way_i*DATA_W +: DATA_W];
            rsp_rdata_way_flat_o <= rd_data_flat;
            rsp_tag_way_flat_o   <= rd_tag_flat;
            rsp_state_way_flat_o <= rd_state_flat;
            rsp_hit_o            <= hit;
            rsp_hit_way_o        <= hit_way;
            rsp_multi_hit_o      <= multi_hit;
         end
      end
   end

endmodule

// File: tb/tb_cpu64_l2_arrays_pipe.sv
// Directed bench for cpu64_l2_arrays_pipe: init sweep timing, tag/data writes, hit detect, streaming.
module tb_cpu64_l2_arrays_pipe;

   localparam int unsigned WAYS   = 16;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned TAG_W  = 50;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   req_valid;
   logic                   req_ready;
   logic [7:0]             req_index;
   logic [2:0]             req_word;
   logic [3:0]             req_way;
   logic                   req_data_we;
   logic [7:0]             req_be;
   logic [DATA_W-1:0]      req_wdata;
   logic                   req_tag_we;
   logic [TAG_W-1:0]       req_tag;
   logic [1:0]             req_state;
   logic [TAG_W-1:0]       req_cmp_tag;
   logic                   rsp_valid;
   logic [DATA_W-1:0]      rsp_rdata;
   logic [WAYS*DATA_W-1:0] rsp_rdata_way_flat;
   logic [WAYS*TAG_W-1:0]  rsp_tag_way_flat;
   logic [WAYS*2-1:0]      rsp_state_way_flat;
   logic                   rsp_hit;
   logic [WAYS-1:0]        rsp_hit_way;
   logic                   rsp_multi_hit;
   logic                   init_done;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   cpu64_l2_arrays_pipe #(
      .WAYS           (16),
      .SETS           (256),
      .WORDS_PER_LINE (8),
      .DATA_W         (64),
      .TAG_W          (50)
   ) dut (
      .clk_i                (clk),
      .rst_i                (rst),
      .req_valid_i          (req_valid),
      .req_ready_o          (req_ready),
      .req_index_i          (req_index),
      .req_word_i           (req_word),
      .req_way_i            (req_way),
      .req_data_we_i        (req_data_we),
      .req_be_i             (req_be),
      .req_wdata_i          (req_wdata),
      .req_tag_we_i         (req_tag_we),
      .req_tag_i            (req_tag),
      .req_state_i          (req_state),
      .req_cmp_tag_i        (req_cmp_tag),
      .rsp_valid_o          (rsp_valid),
      .rsp_rdata_o          (rsp_rdata),
      .rsp_rdata_way_flat_o (rsp_rdata_way_flat),
      .rsp_tag_way_flat_o   (rsp_tag_way_flat),
      .rsp_state_way_flat_o (rsp_state_way_flat),
      .rsp_hit_o            (rsp_hit),
      .rsp_hit_way_o        (rsp_hit_way),
      .rsp_multi_hit_o      (rsp_multi_hit),
      .init_done_o          (init_done)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one request, take the accepting edge, settle 1 time unit past it
   task automatic req(input logic [7:0] idx, input logic [2:0] word, input logic [3:0] way,
                      input logic dwe, input logic [7:0] be, input logic [63:0] wdata,
                      input logic twe, input logic [TAG_W-1:0] tag, input logic [1:0] st,
                      input logic [TAG_W-1:0] cmp);
      req_valid   = 1'b1;
      req_index   = idx;
      req_word    = word;
      req_way     = way;
      req_data_we = dwe;
      req_be      = be;
      req_wdata   = wdata;
      req_tag_we  = twe;
      req_tag     = tag;
      req_state   = st;
      req_cmp_tag = cmp;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid   = 1'b0;
      req_data_we = 1'b0;
      req_tag_we  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag, output int n);
      n = 0;
      while (!req_ready && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, 128'(n), 128'd256);
   endtask

   initial begin
      int n;
      logic [63:0] pat;

      rst = 1'b1;
      req_valid = 1'b0; req_index = '0; req_word = '0; req_way = '0;
      req_data_we = 1'b0; req_be = '0; req_wdata = '0; req_tag_we = 1'b0;
      req_tag = '0; req_state = '0; req_cmp_tag = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", 128'(req_ready), 128'd0);
      chk("reset_done", 128'(init_done), 128'd0);
      chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
      chk("reset_rsp_state", 128'(rsp_state_way_flat), 128'd0);
      chk("reset_rsp_rdata", 128'(rsp_rdata), 128'd0);
      rst = 1'b0;

      // Mid-sweep reset at count 100 restarts the sweep
      repeat (100) begin @(posedge clk); #1; end
      chk("midsweep_ready", 128'(req_ready), 128'd0);
      rst = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      wait_ready("sweep_latency", n);
      chk("init_done_high", 128'(init_done), 128'd1);

      // Lookup after sweep: everything invalid
      req(8'h55, 3'd0, 4'd0, 1'b0, 8'h00, 64'd0, 1'b0, '0, 2'b00, 50'd0);
      chk("post_init_valid", 128'(rsp_valid), 128'd1);
      chk("post_init_state", 128'(rsp_state_way_flat), 128'd0);
      chk("post_init_hit", 128'(rsp_hit), 128'd0);
      idle();
      chk("valid_one_cycle", 128'(rsp_valid), 128'd0);

      // Tag write way 5 set 0x3A, then hit lookup
      req(8'h3A, 3'd0, 4'd5, 1'b0, 8'h00, 64'd0, 1'b1, 50'h1234, 2'b01, 50'h1234);
      chk("tagwr_readfirst_hit", 128'(rsp_hit), 128'd0);
      req(8'h3A, 3'd0, 4'd0, 1'b0, 8'h00, 64'd0, 1'b0, '0, 2'b00, 50'h1234);
      chk("tag_hit", 128'(rsp_hit), 128'd1);
      chk("tag_hit_way", 128'(rsp_hit_way), 128'h0020);
      chk("tag_multi", 128'(rsp_multi_hit), 128'd0);
      chk("tag_way5", 128'(rsp_tag_way_flat[5*TAG_W +: TAG_W]), 128'h1234);
      chk("state_flat", 128'(rsp_state_way_flat), 128'h0000_0400);
      idle();
      chk("hold_hit_way", 128'(rsp_hit_way), 128'h0020);

      // Byte-masked data writes, read-first
      req(8'd7, 3'd3, 4'd2, 1'b1, 8'hFF, 64'h1122334455667788, 1'b0, '0, 2'b00, 50'd0);
      req(8'd7, 3'd3, 4'd2, 1'b1, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, '0, 2'b00, 50'd0);
      chk("data_readfirst", 128'(rsp_rdata), 128'h1122334455667788);
      req(8'd7, 3'd3, 4'd2, 1'b1, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, '0, 2'b00, 50'd0);
      chk("data_masked", 128'(rsp_rdata), 128'h11223344AAAAAAAA);
      chk("data_way_flat", 128'(rsp_rdata_way_flat[2*DATA_W +: DATA_W]), 128'h11223344AAAAAAAA);
      req(8'd7, 3'd3, 4'd2, 1'b0, 8'h00, 64'd0, 1'b0, '0, 2'b00, 50'd0);
      chk("data_be_zero", 128'(rsp_rdata), 128'h11223344AAAAAAAA);

      // Multi-hit at set 0x10; invalid way 4 carries the same tag
      req(8'h10, 3'd0, 4'd9, 1'b0, 8'h00, 64'd0, 1'b1, 50'h77, 2'b11, 50'd0);
      req(8'h10, 3'd0, 4'd3, 1'b0, 8'h00, 64'd0, 1'b1, 50'h77, 2'b01, 50'd0);
      req(8'h10, 3'd0, 4'd4, 1'b0, 8'h00, 64'd0, 1'b1, 50'h77, 2'b00, 50'd0);
      req(8'h10, 3'd0, 4'd0, 1'b0, 8'h00, 64'd0, 1'b0, '0, 2'b00, 50'h77);
      chk("multi_hit_way", 128'(rsp_hit_way), 128'h0008);
      chk("multi_hit_flag", 128'(rsp_multi_hit), 128'd1);
      chk("multi_state", 128'(rsp_state_way_flat), 128'h000C_0040);
      req(8'h11, 3'd0, 4'd4, 1'b0, 8'h00, 64'd0, 1'b1, 50'h77, 2'b00, 50'd0);
      req(8'h11, 3'd0, 4'd0, 1'b0, 8'h00, 64'd0, 1'b0, '0, 2'b00, 50'h77);
      chk("invalid_nohit", 128'(rsp_hit), 128'd0);
      chk("invalid_nohit_way", 128'(rsp_hit_way), 128'd0);
      idle();

      // 64 back-to-back requests: 32 writes then 32 reads of the same words
      for (int i = 0; i < 64; i++) begin
         int j;
         j = i % 32;
         pat = {32'hC0DE0000 + 32'(j), 32'h0BAD0000 + 32'(j * 3)};
         req(8'h20, 3'(j / 16), 4'(j % 16), (i < 32), 8'hFF, pat, 1'b0, '0, 2'b00, 50'd0);
         chk("stream_valid", 128'(rsp_valid), 128'd1);
         if (i >= 32) chk("stream_rdata", 128'(rsp_rdata), 128'(pat));
      end
      idle();
      chk("stream_end_valid", 128'(rsp_valid), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/cpu64_l2_arrays_pipe.md
Name: cpu64_l2_arrays_pipe

Overview:
Parametrised, pipelined successor to the L2 data/tag storage. It holds data, tag and per-line state (valid/dirty) for a WAYS-way, SETS-set cache with a registered 1-cycle read. A valid/ready request port drives it, and it performs a parallel tag compare that yields a one-hot hit vector. After reset, a hardware sweep invalidates all tags/state before the first request is accepted. It sits between the L2 controller FSM and the storage, replacing the combinational-read arrays.

Parameters:
WAYS, 16, associativity (power of 2, >=2)
SETS, 256, number of sets (power of 2, >=2)
WORDS_PER_LINE, 8, 64-bit words per line
DATA_W, 64, data word width (multiple of 8)
TAG_W, 50, tag width
IDX_W, $clog2(SETS), derived; not overridden
WORD_W, $clog2(WORDS_PER_LINE), derived
WAY_W, $clog2(WAYS), derived

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_index_i  in  IDX_W  set index
req_word_i  in  WORD_W  word within line
req_way_i  in  WAY_W  way for writes / selected read
req_data_we_i  in  1  write data word
req_be_i  in  DATA_W/8  byte enables for the data write
req_wdata_i  in  DATA_W  write data
req_tag_we_i  in  1  write tag+state of req_way_i
req_tag_i  in  TAG_W  tag to write
req_state_i  in  2  {dirty,valid} to write with the tag
req_cmp_tag_i  in  TAG_W  tag to compare for hit detection
rsp_valid_o  out  1  response valid (1 cycle)
rsp_rdata_o  out  DATA_W  data of req_way_i
rsp_rdata_way_flat_o  out  WAYS*DATA_W  data word per way, way w at [w*DATA_W +: DATA_W]
rsp_tag_way_flat_o  out  WAYS*TAG_W  tag per way
rsp_state_way_flat_o  out  WAYS*2  {dirty,valid} per way
rsp_hit_o  out  1  any way hit
rsp_hit_way_o  out  WAYS  one-hot hit way
rsp_multi_hit_o  out  1  more than one way matched (error)
init_done_o  out  1  tag/state sweep complete

Behaviour:
- FSM states INIT and READY. rst_i=1 forces INIT with sweep counter 0, rsp_valid_o=0, init_done_o=0, req_ready_o=0, and all rsp_* data registers 0. This holds whenever reset asserts, including mid-sweep and mid-request; the in-flight response is dropped.
- INIT: each cycle writes tag=0 and state=2'b00 to all WAYS at set = counter, then increments the counter. At counter==SETS-1 the FSM goes to READY on the next edge. init_done_o and req_ready_o rise exactly SETS cycles after reset deasserts. The data array is not cleared.
- READY: req_ready_o=1 constantly; no backpressure. Requests are accepted only in READY.
- Accepted request at edge N: rsp_valid_o=1 in cycle N+1 only, with all rsp_* fields registered at edge N.
- Reads are read-first: the response shows contents before that request's own write.
- Writes commit at edge N. A request at N+1 to the same location sees the new data.
- Data write is byte-masked: byte b is replaced iff req_be_i[b]. All-zero be leaves the word unchanged.
- Tag write updates tag and state of req_way_i at req_index_i together.
- Hit: way w matches iff state valid=1 and tag==req_cmp_tag_i, using pre-write contents. rsp_hit_way_o keeps only the lowest matching way. rsp_multi_hit_o=1 if 2+ ways match.
- rsp_* data outputs hold their last value while rsp_valid_o=0.
- req_* inputs are ignored unless valid&ready. Simultaneous data and tag write in one request is legal.
- Out-of-range indices cannot occur (power-of-2 params).

Decomposition:
- Shared package cpu64_l2_pkg:
  - default geometry constants (WAYS, SETS, WORDS_PER_LINE, DATA_W, TAG_W)
  - state bit positions (STATE_VALID=0, STATE_DIRTY=1)
  - FSM encoding (INIT/READY)
- Sub-module cpu64_l2_hit_detect: combinational tag compare, lowest-index one-hot select and multi-hit flag. It is reused by the L2 snoop filter.

Test Plan:
- Reset 3 cycles, release -> req_ready_o/init_done_o rise exactly 256 cycles later; a lookup on any set returns rsp_state_way_flat_o=0, rsp_hit_o=0.
- Assert rst_i at sweep count 100 -> sweep restarts; ready rises 256 cycles after the second release.
- Tag-write way 5 set 0x3A tag 0x1234 state 01, then lookup cmp 0x1234 -> next-cycle rsp_hit_o=1, rsp_hit_way_o=16'h0020, multi_hit=0.
- Data write 64'h1122334455667788 at set 7/word 3/way 2 with be=8'hFF, then write 64'hAAAA...AA with be=8'h0F, then read -> 64'h11223344AAAAAAAA. The same-cycle read on the second write returns the pre-write 64'h1122334455667788.
- Tag 0x77 state valid written to ways 3 and 9 -> hit_way=16'h0008, multi_hit=1. Tag 0x77 with state 00 in way 4 -> no hit from way 4.
- Back-to-back accepted requests every cycle for 64 cycles -> 64 consecutive rsp_valid_o pulses, each matching its request.
